// File: rtl/alu_pkg.sv
// Shared constants for the execute unit: ALUcontrol codes, R-type function
// codes, ALUop encodings and the sequencing FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd12;
    localparam logic [3:0] ALU_SLTU = 4'd14;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_SUB   = 2'd1;
    localparam logic [1:0] OP_RTYPE = 2'd2;
    localparam logic [1:0] OP_ILL   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ALUop/Funct to ALUcontrol decode. Purely combinational; flags any
// undecodable combination as illegal.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] ALUop,
    input  logic [5:0] Funct,
    output logic [3:0] alu_ctrl,
    output logic       illegal
);

    always_comb begin
        alu_ctrl = ALU_AND;
        illegal  = 1'b0;
        case (ALUop)
            OP_ADD: alu_ctrl = ALU_ADD;
            OP_SUB: alu_ctrl = ALU_SUB;
            OP_RTYPE: begin
                case (Funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_XOR:  alu_ctrl = ALU_XOR;
                    FN_NOR:  alu_ctrl = ALU_NOR;
                    FN_SLTU: alu_ctrl = ALU_SLTU;
                    FN_SLL:  alu_ctrl = ALU_SLL;
                    FN_SRL:  alu_ctrl = ALU_SRL;
                    default: illegal  = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: single-cycle logic/arith ops, bit-serial SLL/SRL,
// valid/ready on both sides with a held DONE result under backpressure.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         ALUop,
    input  logic [5:0]         Funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal
);

    state_t             r_state, w_nxt_state;
    logic [WIDTH-1:0]   r_shreg, w_nxt_shreg;
    logic [SHAMT_W-1:0] r_cnt, w_nxt_cnt;
    logic [3:0]         r_ctrl, w_nxt_ctrl;
    logic [WIDTH-1:0]   r_result, w_nxt_result;
    logic               r_zero, w_nxt_zero;
    logic               r_illegal, w_nxt_illegal;

    logic [3:0]         w_dec_ctrl;
    logic               w_dec_illegal;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_shift_val;
    logic               w_accept;
    logic               w_is_shift;

    alu_ctrl_decode u_decode (
        .ALUop    (ALUop),
        .Funct    (Funct),
        .alu_ctrl (w_dec_ctrl),
        .illegal  (w_dec_illegal)
    );

    assign in_ready  = rst_n && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

    assign w_is_shift  = (w_dec_ctrl == ALU_SLL) || (w_dec_ctrl == ALU_SRL);
    assign w_shift_val = (r_ctrl == ALU_SLL) ? (r_shreg << 1) : (r_shreg >> 1);

    // Shift codes land here only with shamt==0, where the result is b itself.
    always_comb begin
        w_alu = '0;
        case (w_dec_ctrl)
            ALU_AND:  w_alu = a & b;
            ALU_OR:   w_alu = a | b;
            ALU_ADD:  w_alu = a + b;
            ALU_SUB:  w_alu = a - b;
            ALU_XOR:  w_alu = a ^ b;
            ALU_NOR:  w_alu = ~(a | b);
            ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL,
            ALU_SRL:  w_alu = b;
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_shreg   = r_shreg;
        w_nxt_cnt     = r_cnt;
        w_nxt_ctrl    = r_ctrl;
        w_nxt_result  = r_result;
        w_nxt_zero    = r_zero;
        w_nxt_illegal = r_illegal;

        case (r_state)
            ST_SHIFT: begin
                w_nxt_shreg = w_shift_val;
                w_nxt_cnt   = r_cnt - 1'b1;
                if (r_cnt == SHAMT_W'(1)) begin
                    w_nxt_result  = w_shift_val;
                    w_nxt_zero    = (w_shift_val == '0);
                    w_nxt_illegal = 1'b0;
                    w_nxt_state   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) w_nxt_state = ST_IDLE;
            end
            default: w_nxt_state = r_state;
        endcase

        // Acceptance is only possible from IDLE or a consumed DONE, so it overrides.
        if (w_accept) begin
            w_nxt_ctrl = w_dec_ctrl;
            if (w_dec_illegal) begin
                w_nxt_result  = '0;
                w_nxt_zero    = 1'b1;
                w_nxt_illegal = 1'b1;
                w_nxt_state   = ST_DONE;
            end else if (w_is_shift && (shamt != '0)) begin
                w_nxt_shreg = b;
                w_nxt_cnt   = shamt;
                w_nxt_state = ST_SHIFT;
            end else begin
                w_nxt_result  = w_alu;
                w_nxt_zero    = (w_alu == '0);
                w_nxt_illegal = 1'b0;
                w_nxt_state   = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_ctrl    <= ALU_AND;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_shreg   <= w_nxt_shreg;
            r_cnt     <= w_nxt_cnt;
            r_ctrl    <= w_nxt_ctrl;
            r_result  <= w_nxt_result;
            r_zero    <= w_nxt_zero;
            r_illegal <= w_nxt_illegal;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, immediate-assertion checks.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUop;
    logic [5:0]  Funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int good_cnt;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUop     (ALUop),
        .Funct     (Funct),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] va, input logic [31:0] vb, input logic [4:0] sh);
        in_valid = 1'b1;
        ALUop    = op;
        Funct    = fn;
        a        = va;
        b        = vb;
        shamt    = sh;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALUop = 2'd0; Funct = 6'h0; a = '0; b = '0; shamt = '0;
        cyc(); cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    result,         32'd0);
        chk("rst_zero",      32'(zero),      32'd0);
        chk("rst_illegal",   32'(illegal),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // ADD via Funct wraps to zero
        out_ready = 1'b1;
        issue(2'd2, 6'h20, 32'hFFFF_FFFF, 32'd1, 5'd0);
        cyc();
        in_valid = 1'b0;
        chk("add_valid",   32'(out_valid), 32'd1);
        chk("add_result",  result,         32'd0);
        chk("add_zero",    32'(zero),      32'd1);
        chk("add_illegal", 32'(illegal),   32'd0);
        cyc();
        chk("add_consumed", 32'(out_valid), 32'd0);

        // SRL by 31: 31 blocked cycles, then result 1
        issue(2'd2, 6'h02, 32'h0, 32'h8000_0000, 5'd31);
        cyc();
        in_valid = 1'b0; b = 32'hDEAD_BEEF; shamt = 5'd3;
        good_cnt = 0;
        repeat (31) begin
            if (!in_ready && !out_valid) good_cnt++;
            cyc();
        end
        chk("srl_blocked_cycles", 32'(good_cnt), 32'd31);
        chk("srl_valid",  32'(out_valid), 32'd1);
        chk("srl_result", result,         32'd1);
        chk("srl_zero",   32'(zero),      32'd0);
        cyc();

        // SLL b=3 by 4 -> 0x30 after 1+4 cycles
        issue(2'd2, 6'h00, 32'h0, 32'd3, 5'd4);
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("sll_not_yet", 32'(out_valid), 32'd0);
        cyc();
        chk("sll_valid",  32'(out_valid), 32'd1);
        chk("sll_result", result,         32'h30);
        cyc();

        // Shift by zero is single-cycle pass-through of b
        issue(2'd2, 6'h00, 32'h0, 32'h1234, 5'd0);
        cyc();
        in_valid = 1'b0;
        chk("sll0_valid",  32'(out_valid), 32'd1);
        chk("sll0_result", result,         32'h1234);
        cyc();

        // Reset mid-SHIFT discards the op
        issue(2'd2, 6'h00, 32'h0, 32'd1, 5'd20);
        cyc();
        in_valid = 1'b0;
        repeat (4) cyc();
        rst_n = 1'b0;
        cyc();
        chk("midrst_valid",    32'(out_valid), 32'd0);
        chk("midrst_result",   result,         32'd0);
        chk("midrst_in_ready", 32'(in_ready),  32'd0);
        rst_n = 1'b1;
        cyc();
        chk("midrst_ready_after", 32'(in_ready), 32'd1);
        repeat (20) cyc();
        chk("midrst_no_result", 32'(out_valid), 32'd0);

        // SLTU 3<5 held under 10 cycles of backpressure; pending op not taken
        out_ready = 1'b0;
        issue(2'd2, 6'h2B, 32'd3, 32'd5, 5'd0);
        cyc();
        issue(2'd0, 6'h00, 32'd100, 32'd100, 5'd0);
        good_cnt = 0;
        repeat (10) begin
            if (out_valid && !in_ready && result === 32'd1 && !zero) good_cnt++;
            cyc();
        end
        chk("sltu_stall_cycles", 32'(good_cnt), 32'd10);
        chk("sltu_result", result, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("sltu_consumed", 32'(out_valid), 32'd0);

        // Illegal Funct, then ALUop=3 back-to-back
        issue(2'd2, 6'h3F, 32'h55, 32'h66, 5'd7);
        cyc();
        chk("ill_fn_valid",   32'(out_valid), 32'd1);
        chk("ill_fn_illegal", 32'(illegal),   32'd1);
        chk("ill_fn_result",  result,         32'd0);
        chk("ill_fn_zero",    32'(zero),      32'd1);
        issue(2'd3, 6'h20, 32'h11, 32'h22, 5'd0);
        cyc();
        chk("ill_op_valid",   32'(out_valid), 32'd1);
        chk("ill_op_illegal", 32'(illegal),   32'd1);
        chk("ill_op_result",  result,         32'd0);
        chk("ill_op_zero",    32'(zero),      32'd1);

        // Back-to-back single-cycle ops, no bubbles
        issue(2'd2, 6'h24, 32'hF0F0, 32'hFF00, 5'd0);
        cyc();
        chk("b2b_and", result, 32'h0000_F000);
        chk("b2b_and_illegal", 32'(illegal), 32'd0);
        chk("b2b_and_zero", 32'(zero), 32'd0);
        issue(2'd2, 6'h25, 32'hF0F0, 32'hFF00, 5'd0);
        cyc();
        chk("b2b_or", result, 32'h0000_FFF0);
        issue(2'd2, 6'h26, 32'hF0F0, 32'hFF00, 5'd0);
        cyc();
        chk("b2b_xor", result, 32'h0000_0FF0);
        issue(2'd2, 6'h27, 32'hF0F0, 32'hFF00, 5'd0);
        cyc();
        chk("b2b_nor", result, 32'hFFFF_000F);
        issue(2'd0, 6'h3F, 32'd10, 32'd20, 5'd0);
        cyc();
        chk("b2b_aluop_add", result, 32'd30);
        issue(2'd1, 6'h00, 32'd5, 32'd7, 5'd0);
        cyc();
        chk("b2b_sub", result, 32'hFFFF_FFFE);
        chk("b2b_sub_valid", 32'(out_valid), 32'd1);

        // DONE -> SHIFT on same edge: out_valid drops while shifting
        issue(2'd2, 6'h02, 32'h0, 32'h100, 5'd4);
        cyc();
        in_valid = 1'b0;
        chk("d2s_drop", 32'(out_valid), 32'd0);
        repeat (3) cyc();
        cyc();
        chk("d2s_valid",  32'(out_valid), 32'd1);
        chk("d2s_result", result,         32'h10);
        cyc();
        chk("d2s_idle", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised multi-cycle execute unit for the single-cycle datapath's successor. It combines ALUop/Funct decode with a registered ALU and an iterative bit-serial shifter, and moves operands in and results out over valid/ready handshakes. It sits between the register-read stage and writeback. Logic ops and add/sub complete in one cycle; SLL/SRL take one cycle per shift bit.

## Interface
Parameters:
- WIDTH, 32, datapath width; must be a power of two and at least 8.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- in_valid  input  1  operands and opcode are presented.
- in_ready  output  1  unit accepts an operation this cycle.
- ALUop  input  2  0=ADD, 1=SUB, 2=decode Funct, 3=illegal.
- Funct  input  6  R-type function code, used only when ALUop==2.
- a  input  WIDTH  operand rs.
- b  input  WIDTH  operand rt; also the shift source.
- shamt  input  SHAMT_W  shift amount.
- out_valid  output  1  result is held and valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- zero  output  1  result==0, registered with result.
- illegal  output  1  the op was undecodable; result is 0.

## Operation
- Decode to a 4-bit ALUcontrol:
  - ADD 0x20 → 2
  - SUB 0x22 → 6
  - AND 0x24 → 0
  - OR 0x25 → 1
  - XOR 0x26 → 9
  - NOR 0x27 → 12
  - SLTU 0x2B → 14
  - SLL 0x00 → 3
  - SRL 0x02 → 4
- ALUop 0 forces code 2; ALUop 1 forces code 6.
- ALUop 3, or any unlisted Funct with ALUop 2: illegal=1, result=0, zero=1. No shift is performed.
- Arithmetic is modulo 2^WIDTH and carries are discarded.
- SLTU gives result = {WIDTH-1 zeros, (a<b unsigned)}.
- SLL/SRL shift b by shamt, zero-filled. `a` is ignored.
- FSM states:
  - IDLE: on in_valid&&in_ready, latch the operands and decoded code.
    - Shift with shamt≠0 → SHIFT; load shift register = b and counter = shamt.
    - All other ops compute → DONE.
  - SHIFT: each cycle, shift the register by 1 in the decoded direction and decrement the counter. When the counter reaches 1 (last step) → DONE, with result = the shifted value.
  - DONE: out_valid=1; result, zero and illegal are held stable until out_ready.
    - On out_ready: if in_valid, accept the next op (same rules as IDLE); otherwise → IDLE.
- in_ready = rst_n && (state==IDLE || (state==DONE && out_ready)).
- in_ready is low throughout SHIFT; inputs presented then are ignored.
- Shift with shamt==0 takes the single-cycle path: result=b.

## Timing
- Reset (rst_n low at a clock edge):
  - state=IDLE, out_valid=0, result=0, zero=0, illegal=0, counter=0.
  - Any in-flight op is discarded, including mid-SHIFT or a held DONE result.
- While rst_n is low, in_ready=0.
- Latency, from the accept edge to out_valid high:
  - 1 cycle for non-shift, illegal and shamt==0 ops.
  - 1+shamt cycles for shifts; the maximum is WIDTH cycles (shamt=WIDTH-1).
- Throughput:
  - One single-cycle op per clock when out_ready is held high (back-to-back through DONE).
  - Shifts block new input for shamt cycles.
- Backpressure:
  - out_ready low in DONE holds all outputs unchanged indefinitely.
  - in_ready is then low.
- Inputs are sampled only on the accept edge. Changes to a/b/ALUop/Funct/shamt after acceptance have no effect.
- Simultaneous out_ready and in_valid in DONE:
  - The old result is consumed and the new op is accepted on the same edge.
  - out_valid stays high only if the new op is single-cycle; otherwise it drops while in SHIFT.

## Structure
- Package alu_pkg holds:
  - the ALUcontrol localparams (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SLL=3, ALU_SRL=4, ALU_SUB=6, ALU_XOR=9, ALU_NOR=12, ALU_SLTU=14);
  - the Funct code constants;
  - the ALUop constants;
  - the FSM state encoding (IDLE/SHIFT/DONE, 2 bits).
- One combinational sub-module, alu_ctrl_decode: ALUop and Funct in; ALUcontrol and illegal out.
- The top holds the FSM, shift register, counter, result/flag registers and the handshake.

## Test plan
- Reset mid-SHIFT: SLL b=1, shamt=20; pull rst_n low at cycle 5 → next edge out_valid=0, result=0, in_ready=1 after release.
- ALUop=2, Funct=0x20, a=0xFFFFFFFF, b=1, out_ready=1 → one cycle later out_valid=1, result=0, zero=1, illegal=0.
- SRL b=0x80000000, shamt=31 → in_ready low for 31 cycles; out_valid on cycle 32; result=1.
- SLTU a=3, b=5, then stall out_ready low for 10 cycles → result=1 held stable; in_ready=0 throughout.
- ALUop=2, Funct=0x3F → illegal=1, result=0, zero=1 after 1 cycle. Then ALUop=3 → same response.
- Back-to-back with out_ready=1: in_valid held for AND 0xF0F0&0xFF00, OR, XOR, NOR, SUB 5-7 → results 0xF000, …, 0xFFFFFFFE on consecutive cycles, no bubbles.
